// File: rtl/led_share_pkg.sv
// Shared types and default timing for the status-LED arbiter.
// Pattern bit order: bit0 drives led_1, bit1 drives led_2.
package led_share_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_TICK_DIV    = 16000;
  localparam int DEF_DWELL_TICKS = 100;
  localparam int DEF_BLINK_TICKS = 250;

  localparam int LED1_BIT = 0;
  localparam int LED2_BIT = 1;

  function automatic logic [1:0] led_drive(
    input logic [1:0] p,
    input logic       bl,
    input logic       ph
  );
    return bl ? (p & {ph, ph}) : p;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
// Never restarted by the arbiter, so the time base stays steady.
module led_tick_gen #(
  parameter int TICK_DIV = 16000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt_q;
  logic [CW-1:0] tick_cnt_d;

  always_comb begin
    tick       = (tick_cnt_q == LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/led_share_arbiter.sv
// Round-robin owner of the two status LEDs with minimum dwell,
// blink support and an idle heartbeat when nobody owns them.
module led_share_arbiter
  import led_share_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int DWELL_TICKS = DEF_DWELL_TICKS,
  parameter int BLINK_TICKS = DEF_BLINK_TICKS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] pat,
  input  logic [N_REQ-1:0]   blink,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               led_1,
  output logic               led_2
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DW = $clog2(DWELL_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  localparam logic [IW-1:0] LAST_IDX   = IW'(N_REQ - 1);
  localparam logic [DW-1:0] DWELL_MAX  = DW'(DWELL_TICKS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  function automatic logic [IW-1:0] idx_inc(
    input logic [IW-1:0] i
  );
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  // First requester at or after start, wrapping modulo N_REQ.
  function automatic logic [IW-1:0] rr_pick(
    input logic [N_REQ-1:0] r,
    input logic [IW-1:0]    start
  );
    logic [IW-1:0] idx;
    logic [IW-1:0] pick;
    logic          found;
    idx   = start;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = idx_inc(idx);
    end
    return pick;
  endfunction

  function automatic logic [1:0] pat_of(
    input logic [2*N_REQ-1:0] p,
    input logic [IW-1:0]      i
  );
    logic [1:0] v;
    v = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (i == IW'(k)) v = p[2*k +: 2];
    end
    return v;
  endfunction

  logic tick;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [1:0]    pat_q, pat_d;
  logic          blk_q, blk_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic [1:0]    led_q, led_d;

  logic          grant;
  logic [IW-1:0] new_owner;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    dwell_d     = dwell_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    pat_d       = pat_q;
    blk_d       = blk_q;
    grant       = 1'b0;
    new_owner   = owner_q;

    if (tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant     = 1'b1;
          new_owner = rr_pick(req, rr_ptr_q);
        end
      end
      OWN: begin
        if (tick && dwell_q != DWELL_MAX) begin
          dwell_d = dwell_q + 1'b1;
        end
        if (req[owner_q]) begin
          pat_d = pat_of(pat, owner_q);
          blk_d = blink[owner_q];
        end else if (dwell_q == DWELL_MAX) begin
          // Owner's own req is low here, so req holds only the others.
          rr_ptr_d = idx_inc(owner_q);
          if (|req) begin
            grant     = 1'b1;
            new_owner = rr_pick(req, idx_inc(owner_q));
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase

    // A fresh grant restarts dwell and blink even on a tick cycle.
    if (grant) begin
      state_d     = OWN;
      owner_d     = new_owner;
      dwell_d     = '0;
      blink_cnt_d = '0;
      phase_d     = 1'b1;
      pat_d       = pat_of(pat, new_owner);
      blk_d       = blink[new_owner];
    end

    gnt_d = '0;
    if (state_d == OWN) gnt_d[owner_d] = 1'b1;
    busy_d = (state_d == OWN);
    if (state_d == OWN) begin
      led_d = led_drive(pat_d, blk_d, phase_d);
    end else begin
      led_d = {~phase_d, phase_d};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      dwell_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      pat_q       <= '0;
      blk_q       <= 1'b0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      led_q       <= 2'b01;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      dwell_q     <= dwell_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      pat_q       <= pat_d;
      blk_q       <= blk_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      led_q       <= led_d;
    end
  end

  assign gnt   = gnt_q;
  assign busy  = busy_q;
  assign led_1 = led_q[LED1_BIT];
  assign led_2 = led_q[LED2_BIT];

endmodule

// File: tb/tb_led_share_arbiter.sv
// Scoreboard bench for led_share_arbiter with a fast time base.
// Expectations are queued per cycle; monitors pop and compare.
module tb_led_share_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [2*N-1:0] pat = '0;
  logic [N-1:0] blink = '0;
  logic [N-1:0] gnt;
  logic         busy;
  logic         led_1;
  logic         led_2;

  led_share_arbiter #(
    .N_REQ       (4),
    .TICK_DIV    (4),
    .DWELL_TICKS (3),
    .BLINK_TICKS (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .pat   (pat),
    .blink (blink),
    .gnt   (gnt),
    .busy  (busy),
    .led_1 (led_1),
    .led_2 (led_2)
  );

  always #5 clk = ~clk;

  // Edges since the last reset release.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int           cyc;
    logic [N-1:0] gnt;
    logic         busy;
    logic         l1;
    logic         l2;
    string        name;
  } exp_t;

  exp_t         tq[$];
  exp_t         rq[$];
  logic [N-1:0] gq[$];
  logic         gmon_en = 1'b0;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk_out(input exp_t e);
    n_run++;
    if (gnt !== e.gnt || busy !== e.busy ||
        led_1 !== e.l1 || led_2 !== e.l2) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got gnt=%b busy=%b led1=%b led2=%b, want gnt=%b busy=%b led1=%b led2=%b",
               e.name, cyc, gnt, busy, led_1, led_2,
               e.gnt, e.busy, e.l1, e.l2);
    end
  endtask

  task automatic expect_at(input int n, input logic [N-1:0] g,
                           input logic b, input logic l1,
                           input logic l2, input string nm);
    exp_t e;
    e.cyc = n; e.gnt = g; e.busy = b;
    e.l1 = l1; e.l2 = l2; e.name = nm;
    tq.push_back(e);
  endtask

  // Cycle-timed output monitor plus grant-sequence monitor.
  initial begin : mon
    exp_t         e;
    logic [N-1:0] gprev;
    logic [N-1:0] gexp;
    gprev = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (tq.size() > 0 && tq[0].cyc <= cyc) begin
          e = tq.pop_front();
          if (e.cyc < cyc) begin
            n_run++;
            n_fail++;
            $display("FAIL %s: check for cyc %0d missed at cyc %0d",
                     e.name, e.cyc, cyc);
          end else begin
            chk_out(e);
          end
        end
        if (gmon_en && gnt !== gprev) begin
          n_run++;
          if (gq.size() == 0) begin
            n_fail++;
            $display("FAIL gnt_seq @cyc %0d: got gnt=%b, want no change",
                     cyc, gnt);
          end else begin
            gexp = gq.pop_front();
            if (gnt !== gexp) begin
              n_fail++;
              $display("FAIL gnt_seq @cyc %0d: got gnt=%b, want %b",
                       cyc, gnt, gexp);
            end
          end
        end
      end
      gprev = gnt;
    end
  end

  // Reset must take effect without waiting for a clock edge.
  initial begin : rst_mon
    exp_t e;
    forever begin
      @(negedge rst_n);
      #1;
      if (rq.size() > 0) begin
        e = rq.pop_front();
        chk_out(e);
      end
    end
  end

  task automatic at(input int n);
    int g;
    g = 0;
    while (cyc < n && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (cyc != n) begin
      n_run++;
      n_fail++;
      $display("FAIL sync: at cyc %0d, want %0d", cyc, n);
    end
  endtask

  task automatic drain(input string nm);
    int g;
    g = 0;
    while ((tq.size() > 0 || gq.size() > 0) && g < 300) begin
      @(negedge clk);
      g++;
    end
    #1;
    if (tq.size() > 0 || gq.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL %s_drain: got %0d/%0d pending, want 0/0",
               nm, tq.size(), gq.size());
      tq.delete();
      gq.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t r;

    // Heartbeat, steady grant, blink pulse grant.
    do_reset();
    expect_at(0,  4'b0000, 0, 1, 0, "t1_reset");
    expect_at(7,  4'b0000, 0, 1, 0, "t1_hb7");
    expect_at(8,  4'b0000, 0, 0, 1, "t1_hb8");
    expect_at(15, 4'b0000, 0, 0, 1, "t1_hb15");
    expect_at(16, 4'b0000, 0, 1, 0, "t1_hb16");
    expect_at(39, 4'b0000, 0, 1, 0, "t1_hb39");
    expect_at(40, 4'b0000, 0, 0, 1, "t1_hb40");
    expect_at(43, 4'b0000, 0, 0, 1, "t2_pre");
    expect_at(44, 4'b0001, 1, 1, 1, "t2_grant");
    expect_at(53, 4'b0001, 1, 1, 1, "t2_steady");
    expect_at(55, 4'b0001, 1, 0, 1, "t2_relatch");
    expect_at(60, 4'b0001, 1, 0, 1, "t2_hold");
    expect_at(61, 4'b0000, 0, 1, 0, "t2_idle");
    expect_at(68, 4'b0000, 0, 0, 1, "t2_hb68");
    expect_at(71, 4'b0000, 0, 0, 1, "t3_pre");
    expect_at(72, 4'b0001, 1, 1, 0, "t3_grant");
    expect_at(79, 4'b0001, 1, 1, 0, "t3_on");
    expect_at(80, 4'b0001, 1, 0, 0, "t3_off");
    expect_at(84, 4'b0001, 1, 0, 0, "t3_dwell");
    expect_at(85, 4'b0000, 0, 0, 1, "t3_idle");
    expect_at(88, 4'b0000, 0, 1, 0, "t3_hb88");

    at(43);
    req = 4'b0001; pat[1:0] = 2'b11; blink = '0;
    at(54);
    pat[1:0] = 2'b10;
    at(60);
    req = '0;
    at(71);
    req = 4'b0001; pat[1:0] = 2'b01; blink = 4'b0001;
    at(72);
    req = '0; pat[1:0] = 2'b11;
    drain("epoch_a");

    // All four requesting: round-robin, direct handovers.
    req = '0; blink = '0;
    pat = {2'b01, 2'b11, 2'b10, 2'b01};
    do_reset();
    gmon_en = 1'b1;
    gq.push_back(4'b0001);
    gq.push_back(4'b0010);
    gq.push_back(4'b0100);
    gq.push_back(4'b1000);
    gq.push_back(4'b0000);
    expect_at(3,  4'b0000, 0, 1, 0, "t4_pre");
    expect_at(4,  4'b0001, 1, 1, 0, "t4_own0");
    expect_at(16, 4'b0001, 1, 1, 0, "t4_own0_end");
    expect_at(17, 4'b0010, 1, 0, 1, "t4_own1");
    expect_at(32, 4'b0010, 1, 0, 1, "t4_own1_keep");
    expect_at(33, 4'b0100, 1, 1, 1, "t4_own2");
    expect_at(44, 4'b0100, 1, 1, 1, "t4_own2_end");
    expect_at(45, 4'b1000, 1, 1, 0, "t4_own3");
    expect_at(56, 4'b1000, 1, 1, 0, "t4_own3_end");
    expect_at(57, 4'b0000, 0, 0, 1, "t4_idle");
    at(3);  req = 4'b1111;
    at(16); req = 4'b1110;
    at(32); req = 4'b1100;
    at(44); req = 4'b1000;
    at(56); req = 4'b0000;
    drain("epoch_b");
    gmon_en = 1'b0;

    // Asynchronous reset in the middle of owner 2's dwell.
    req = '0;
    pat = {2'b00, 2'b11, 2'b00, 2'b00};
    do_reset();
    expect_at(4, 4'b0100, 1, 1, 1, "t5_own2");
    expect_at(5, 4'b0100, 1, 1, 1, "t5_dwell");
    at(3); req = 4'b0100;
    drain("epoch_c");
    at(6);
    #2;
    r.cyc = 0; r.gnt = '0; r.busy = 1'b0;
    r.l1 = 1'b1; r.l2 = 1'b0; r.name = "t5_async_rst";
    rq.push_back(r);
    rst_n = 1'b0;
    req = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Pointer wrap after owner 3, then req3 waits behind req1.
    pat = {2'b01, 2'b00, 2'b11, 2'b10};
    blink = '0;
    gmon_en = 1'b1;
    gq.push_back(4'b1000);
    gq.push_back(4'b0001);
    gq.push_back(4'b0010);
    gq.push_back(4'b1000);
    gq.push_back(4'b0000);
    expect_at(4,  4'b1000, 1, 1, 0, "t6_own3");
    expect_at(16, 4'b1000, 1, 1, 0, "t6_own3_end");
    expect_at(17, 4'b0001, 1, 0, 1, "t6_wrap_own0");
    expect_at(28, 4'b0001, 1, 0, 1, "t6_own0_end");
    expect_at(29, 4'b0010, 1, 1, 1, "t6_own1");
    expect_at(40, 4'b0010, 1, 1, 1, "t6_own1_end");
    expect_at(41, 4'b1000, 1, 1, 0, "t6_own3_again");
    expect_at(53, 4'b0000, 0, 0, 1, "t6_idle");
    at(3);  req = 4'b1000;
    at(5);  req = 4'b1011;
    at(16); req = 4'b0011;
    at(20); req = 4'b1011;
    at(28); req = 4'b1010;
    at(40); req = 4'b1000;
    at(41); req = 4'b0000;
    drain("epoch_d");
    gmon_en = 1'b0;

    if (rq.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL rst_pending: got %0d, want 0", rq.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
